// File: rtl/dict_pkg.sv
// Dictionary parameters shared by the compressor and decompressor dictionaries.
// Both sides import these so slot numbering and index width always agree.
package dict_pkg;
    localparam int DICT_WORDS  = 16;
    localparam int DICT_IDX_W  = $clog2(DICT_WORDS);
    localparam int DICT_DATA_W = 32;

    typedef logic [DICT_DATA_W-1:0] dict_word_t;
    typedef logic [DICT_IDX_W-1:0]  dict_idx_t;
endpackage

// File: rtl/decomp_dict_if.sv
// Push/read bus of the decompressor dictionary.
// master: code decoder / word assembler side, slave: decomp_dict.
interface decomp_dict_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int TOTAL_WORDS = 16
);
    localparam int IDX_W = $clog2(TOTAL_WORDS);

    logic                  wr;
    logic                  wr2;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] w_data2;
    logic                  rd;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd2;
    logic [IDX_W-1:0]      rd_idx2;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic [DATA_WIDTH-1:0] o_rd_data2;
    logic                  o_rd_valid2;
    logic                  o_rd_err;
    logic [IDX_W:0]        o_count;
    logic                  full;

    modport master (
        output wr, wr2, w_data, w_data2, rd, rd_idx, rd2, rd_idx2,
        input  o_rd_data, o_rd_valid, o_rd_data2, o_rd_valid2, o_rd_err, o_count, full
    );

    modport slave (
        input  wr, wr2, w_data, w_data2, rd, rd_idx, rd2, rd_idx2,
        output o_rd_data, o_rd_valid, o_rd_data2, o_rd_valid2, o_rd_err, o_count, full
    );
endinterface

// File: rtl/dict_mem_2r2w.sv
// Dictionary storage: 2 write ports, 2 asynchronous read ports, no reset.
// Reads see the contents before this edge's writes (read-before-write when registered by the caller).
module dict_mem_2r2w #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [AW-1:0]         raddr0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic [AW-1:0]         raddr1,
    output logic [DATA_WIDTH-1:0] rdata1
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port 1 is the later word in push order, so it wins on a (degenerate) address clash.
    always_ff @(posedge i_clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
endmodule

// File: rtl/decomp_dict.sv
// Decompressor FIFO dictionary: up to 2 pushes and 2 registered reads per cycle.
// Read latency 1 cycle, fully pipelined; no backpressure, unwritten-slot reads return 0 and flag o_rd_err.
module decomp_dict
    import dict_pkg::*;
#(
    parameter int DATA_WIDTH  = DICT_DATA_W,
    parameter int TOTAL_WORDS = DICT_WORDS,
    localparam int IDX_W      = $clog2(TOTAL_WORDS)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    decomp_dict_if.slave bus
);
    localparam logic [IDX_W+1:0] FULL_SUM = (IDX_W+2)'(TOTAL_WORDS);

    logic [IDX_W-1:0]       wr_ptr;
    logic [IDX_W:0]         count;
    logic [TOTAL_WORDS-1:0] vld;
    logic [TOTAL_WORDS-1:0] vld_next;

    logic [1:0]             push_cnt;
    logic [IDX_W+1:0]       count_sum;
    logic [IDX_W:0]         count_next;

    logic                   we0;
    logic                   we1;
    logic [IDX_W-1:0]       waddr0;
    logic [IDX_W-1:0]       waddr1;
    logic [DATA_WIDTH-1:0]  wdata0;

    logic [DATA_WIDTH-1:0]  mem_rd0;
    logic [DATA_WIDTH-1:0]  mem_rd1;
    logic                   hit0;
    logic                   hit1;

    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic [DATA_WIDTH-1:0]  rd_data2_q;
    logic                   rd_valid_q;
    logic                   rd_valid2_q;
    logic                   rd_err_q;

    // A lone push always takes slot wr_ptr, whichever of wr/wr2 carried it.
    assign we0    = bus.wr | bus.wr2;
    assign we1    = bus.wr & bus.wr2;
    assign waddr0 = wr_ptr;
    assign waddr1 = wr_ptr + IDX_W'(1);
    assign wdata0 = bus.wr ? bus.w_data : bus.w_data2;

    assign push_cnt   = {1'b0, bus.wr} + {1'b0, bus.wr2};
    assign count_sum  = {1'b0, count} + (IDX_W+2)'(push_cnt);
    assign count_next = (count_sum >= FULL_SUM) ? FULL_SUM[IDX_W:0] : count_sum[IDX_W:0];

    always_comb begin
        vld_next = vld;
        if (we0) vld_next[waddr0] = 1'b1;
        if (we1) vld_next[waddr1] = 1'b1;
    end

    dict_mem_2r2w #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TOTAL_WORDS)
    ) u_mem (
        .i_clk  (i_clk),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (bus.w_data2),
        .raddr0 (bus.rd_idx),
        .rdata0 (mem_rd0),
        .raddr1 (bus.rd_idx2),
        .rdata1 (mem_rd1)
    );

    // Valid bits are sampled pre-write, matching the memory's read-before-write view.
    assign hit0 = vld[bus.rd_idx];
    assign hit1 = vld[bus.rd_idx2];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            wr_ptr <= wr_ptr + IDX_W'(push_cnt);
            count  <= count_next;
            vld    <= vld_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_data_q   <= '0;
            rd_data2_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_valid2_q <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            if (bus.rd)  rd_data_q  <= hit0 ? mem_rd0 : '0;
            if (bus.rd2) rd_data2_q <= hit1 ? mem_rd1 : '0;
            rd_valid_q  <= bus.rd;
            rd_valid2_q <= bus.rd2;
            rd_err_q    <= (bus.rd & ~hit0) | (bus.rd2 & ~hit1);
        end
    end

    assign bus.o_rd_data   = rd_data_q;
    assign bus.o_rd_data2  = rd_data2_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_rd_valid2 = rd_valid2_q;
    assign bus.o_rd_err    = rd_err_q;
    assign bus.o_count     = count;
    assign bus.full        = (count == FULL_SUM[IDX_W:0]);
endmodule

// File: tb/tb_decomp_dict.sv
// Bench for decomp_dict: directed table, corner sequences, then random traffic vs a push-history model.
`timescale 1ns/1ps
module tb_decomp_dict;
    localparam int DW = 32;
    localparam int NW = 16;
    localparam int IW = $clog2(NW);

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 i_clk = ~i_clk;

    decomp_dict_if #(.DATA_WIDTH(DW), .TOTAL_WORDS(NW)) bus ();

    decomp_dict #(.DATA_WIDTH(DW), .TOTAL_WORDS(NW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          wr, wr2;
        logic [DW-1:0] d, d2;
        logic          rd;
        logic [IW-1:0] idx;
        logic          rd2;
        logic [IW-1:0] idx2;
        logic [DW-1:0] e_d, e_d2;
        logic          e_v, e_v2, e_err;
        int            e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the ordered list of words pushed since reset.
    // Push number k lands in slot k mod NW, so a slot holds its most recent such push.
    logic [DW-1:0] hist[$];

    function automatic logic [DW-1:0] mdl_read(input int idx, output bit hit);
        hit = 1'b0;
        for (int k = hist.size() - 1; k >= 0 && k >= hist.size() - NW; k--) begin
            if (k % NW == idx) begin
                hit = 1'b1;
                return hist[k];
            end
        end
        return '0;
    endfunction

    function automatic int mdl_count();
        return (hist.size() > NW) ? NW : hist.size();
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic wr2, input logic [DW-1:0] d, input logic [DW-1:0] d2,
                         input logic rd, input logic [IW-1:0] idx, input logic rd2, input logic [IW-1:0] idx2);
        bus.wr = wr; bus.wr2 = wr2; bus.w_data = d; bus.w_data2 = d2;
        bus.rd = rd; bus.rd_idx = idx; bus.rd2 = rd2; bus.rd_idx2 = idx2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_reset = 1'b1;
        hist.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic addv(input logic wr, input logic wr2, input logic [DW-1:0] d, input logic [DW-1:0] d2,
                        input logic rd, input int idx, input logic rd2, input int idx2,
                        input logic [DW-1:0] e_d, input logic e_v, input logic [DW-1:0] e_d2,
                        input logic e_v2, input logic e_err, input int e_cnt);
        vec_t v;
        v.wr = wr; v.wr2 = wr2; v.d = d; v.d2 = d2;
        v.rd = rd; v.idx = IW'(idx); v.rd2 = rd2; v.idx2 = IW'(idx2);
        v.e_d = e_d; v.e_v = e_v; v.e_d2 = e_d2; v.e_v2 = e_v2; v.e_err = e_err; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    logic [DW-1:0] e_d, e_d2;
    logic          e_v, e_v2, e_err;
    bit            h0, h1;
    logic [DW-1:0] m0, m1;
    logic          r_wr, r_wr2, r_rd, r_rd2;
    logic [DW-1:0] r_d, r_d2;
    logic [IW-1:0] r_idx, r_idx2;

    initial begin
        // Directed table: fill, read, wrap, read-before-write, lone wr2.
        for (int i = 0; i < 8; i++)
            addv(1, 1, DW'(2*i), DW'(2*i+1), 0, 0, 0, 0, '0, 0, '0, 0, 0, 2*i+2);
        addv(0, 0, 0, 0, 1, 5, 1, 10, 32'h05, 1, 32'h0A, 1, 0, 16);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 32'h05, 0, 32'h0A, 0, 0, 16);
        addv(1, 1, 32'hDEAD0000, 32'hDEAD0001, 0, 0, 0, 0, 32'h05, 0, 32'h0A, 0, 0, 16);
        addv(0, 0, 0, 0, 1, 0, 1, 2, 32'hDEAD0000, 1, 32'h02, 1, 0, 16);
        addv(1, 1, 32'h12, 32'h13, 0, 0, 0, 0, 32'hDEAD0000, 0, 32'h02, 0, 0, 16);
        addv(1, 0, 32'h44, 0, 1, 4, 1, 3, 32'h04, 1, 32'h13, 1, 0, 16);
        addv(0, 0, 0, 0, 1, 4, 0, 0, 32'h44, 1, 32'h13, 0, 0, 16);
        addv(0, 1, 0, 32'hCAFEF00D, 0, 0, 0, 0, 32'h44, 0, 32'h13, 0, 0, 16);
        addv(0, 0, 0, 0, 1, 5, 1, 6, 32'hCAFEF00D, 1, 32'h06, 1, 0, 16);
        addv(1, 0, 32'h77, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 32'h06, 0, 0, 16);
        addv(0, 0, 0, 0, 1, 7, 1, 6, 32'h07, 1, 32'h77, 1, 0, 16);

        idle();
        #2;
        chk("reset_rd_data", bus.o_rd_data, 0);
        chk("reset_rd_valid", bus.o_rd_valid, 0);
        chk("reset_rd_valid2", bus.o_rd_valid2, 0);
        chk("reset_rd_err", bus.o_rd_err, 0);
        chk("reset_count", bus.o_count, 0);
        chk("reset_full", bus.full, 0);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].wr2, vecs[i].d, vecs[i].d2,
                  vecs[i].rd, vecs[i].idx, vecs[i].rd2, vecs[i].idx2);
            tick();
            chk($sformatf("v%0d_rd_data", i), bus.o_rd_data, vecs[i].e_d);
            chk($sformatf("v%0d_rd_valid", i), bus.o_rd_valid, vecs[i].e_v);
            chk($sformatf("v%0d_rd_data2", i), bus.o_rd_data2, vecs[i].e_d2);
            chk($sformatf("v%0d_rd_valid2", i), bus.o_rd_valid2, vecs[i].e_v2);
            chk($sformatf("v%0d_rd_err", i), bus.o_rd_err, vecs[i].e_err);
            chk($sformatf("v%0d_count", i), bus.o_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_full", i), bus.full, vecs[i].e_cnt == NW);
        end

        // Unwritten slot read after three single pushes.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h100 + DW'(i), '0, 0, '0, 0, '0);
            tick();
        end
        drive(0, 0, '0, '0, 1, IW'(7), 0, '0);
        tick();
        chk("unwr_rd_data", bus.o_rd_data, 0);
        chk("unwr_rd_valid", bus.o_rd_valid, 1);
        chk("unwr_rd_err", bus.o_rd_err, 1);
        chk("unwr_count", bus.o_count, 3);
        drive(0, 0, '0, '0, 1, IW'(2), 0, '0);
        tick();
        chk("wr_slot2_data", bus.o_rd_data, 32'h102);
        chk("wr_slot2_err", bus.o_rd_err, 0);

        // Reset in the middle of a read.
        drive(0, 0, '0, '0, 1, IW'(0), 0, '0);
        tick();
        chk("prerst_rd_valid", bus.o_rd_valid, 1);
        chk("prerst_rd_data", bus.o_rd_data, 32'h100);
        #2;
        i_reset = 1'b1;
        #1;
        chk("midrst_rd_valid", bus.o_rd_valid, 0);
        chk("midrst_rd_data", bus.o_rd_data, 0);
        chk("midrst_count", bus.o_count, 0);
        chk("midrst_full", bus.full, 0);
        tick();
        chk("inrst_rd_valid", bus.o_rd_valid, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        idle();
        tick();
        chk("postrst_rd_valid", bus.o_rd_valid, 0);
        drive(0, 0, '0, '0, 1, IW'(0), 0, '0);
        tick();
        chk("postrst_rd_valid1", bus.o_rd_valid, 1);
        chk("postrst_rd_err", bus.o_rd_err, 1);
        chk("postrst_rd_data", bus.o_rd_data, 0);

        // Random traffic against the push-history model.
        do_reset();
        e_d = '0; e_d2 = '0;
        for (int c = 0; c < 600; c++) begin
            r_wr   = ($urandom_range(0, 3) != 0) && (c > 40 || $urandom_range(0, 1) == 1);
            r_wr2  = $urandom_range(0, 1) == 1;
            r_d    = $urandom();
            r_d2   = $urandom();
            r_rd   = $urandom_range(0, 1) == 1;
            r_rd2  = $urandom_range(0, 1) == 1;
            r_idx  = IW'($urandom_range(0, NW - 1));
            r_idx2 = ($urandom_range(0, 3) == 0) ? r_idx : IW'($urandom_range(0, NW - 1));
            drive(r_wr, r_wr2, r_d, r_d2, r_rd, r_idx, r_rd2, r_idx2);

            m0 = mdl_read(int'(r_idx), h0);
            m1 = mdl_read(int'(r_idx2), h1);
            e_v = r_rd; e_v2 = r_rd2;
            if (r_rd)  e_d  = m0;
            if (r_rd2) e_d2 = m1;
            e_err = (r_rd && !h0) || (r_rd2 && !h1);
            if (r_wr)  hist.push_back(r_d);
            if (r_wr2) hist.push_back(r_d2);

            tick();
            chk("rnd_rd_data", bus.o_rd_data, e_d);
            chk("rnd_rd_valid", bus.o_rd_valid, e_v);
            chk("rnd_rd_data2", bus.o_rd_data2, e_d2);
            chk("rnd_rd_valid2", bus.o_rd_valid2, e_v2);
            chk("rnd_rd_err", bus.o_rd_err, e_err);
            chk("rnd_count", bus.o_count, mdl_count());
            chk("rnd_full", bus.full, mdl_count() == NW);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
